axil_cmd_slave: RTL and testbench
=================================

AXIL_CMD_SLAVE -- requirements
Module: axil_cmd_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, AXI-Lite address width in bits; only bits [3:2] are decoded.
REQ-002 SHALL have parameter SCRATCH_RST, default 32'h0000_0000, reset value of the SCRATCH register.
REQ-003 SHALL have port usr_clk, input, 1: clock for all logic.
REQ-004 SHALL have port usr_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports s_axil_awaddr in ADDR_W, s_axil_awvalid in 1, s_axil_awready out 1: AXI-Lite write address channel.
REQ-006 SHALL have ports s_axil_wdata in 32, s_axil_wstrb in 4, s_axil_wvalid in 1, s_axil_wready out 1: AXI-Lite write data channel.
REQ-007 SHALL have ports s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1: AXI-Lite write response channel.
REQ-008 SHALL have ports s_axil_araddr in ADDR_W, s_axil_arvalid in 1, s_axil_arready out 1: AXI-Lite read address channel.
REQ-009 SHALL have ports s_axil_rdata out 32, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1: AXI-Lite read data channel.
REQ-010 SHALL have port cmd_data, output, 32: last committed CMD word; this is the word the downstream LED/stop decoder consumes.
REQ-011 SHALL have port cmd_vld, output, 1: single-cycle pulse when cmd_data is updated.
REQ-012 SHALL have ports led0_in in 1 and stop_in in 1: status from the downstream decoder, sampled for STATUS reads.

Function
REQ-013 SHALL decode the register map as 0x0 CMD (RW), 0x4 STATUS (RO), 0x8 SCRATCH (RW), 0xC CMD_COUNT (RO); bits [1:0] and bits above [3] are ignored.
REQ-014 SHALL implement write FSM W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP; awready=1 only in W_IDLE/W_HAVE_D and wready=1 only in W_IDLE/W_HAVE_A.
REQ-015 SHALL transition W_IDLE to W_RESP when AW and W handshake in the same cycle, to W_HAVE_A on AW only, and to W_HAVE_D on W only; W_HAVE_A/W_HAVE_D go to W_RESP on the missing handshake.
REQ-016 SHALL commit the register write on the cycle of entry into W_RESP, and assert bvalid in W_RESP, holding bvalid and bresp stable until bready; the FSM then returns to W_IDLE.
REQ-017 SHALL apply wstrb byte-wise to CMD and SCRATCH; a write with wstrb=0 is a no-op that still returns OKAY.
REQ-018 SHALL answer writes to CMD/SCRATCH with bresp OKAY (2'b00), and writes to STATUS/CMD_COUNT with SLVERR (2'b10) and no state change.
REQ-019 SHALL pulse cmd_vld for exactly one cycle, coincident with cmd_data taking its new value, for every CMD write with wstrb nonzero.
REQ-020 SHALL increment CMD_COUNT (32 bits) on each cmd_vld pulse, wrapping from 32'hFFFF_FFFF to 0.
REQ-021 SHALL implement read FSM R_IDLE, R_DATA; arready=1 only in R_IDLE; on the AR handshake, latch rdata/rresp=OKAY and enter R_DATA with rvalid=1 the next cycle.
REQ-022 SHALL hold rvalid, rdata and rresp stable in R_DATA until rready, then return to R_IDLE; back-to-back reads have 1 idle cycle between them.
REQ-023 SHALL return STATUS as {30'b0, stop_in, led0_in}, sampled at the AR handshake.
REQ-024 SHALL, when a read and a write to the same register resolve in the same cycle, return the pre-write value.
REQ-025 SHALL keep the write and read FSMs independent; neither blocks the other.

Reset
REQ-026 SHALL, on usr_rst_n low, asynchronously clear cmd_data, cmd_vld, CMD_COUNT, bvalid, rvalid, rdata, bresp and rresp to 0, load SCRATCH with SCRATCH_RST, and force both FSMs to their idle state.
REQ-027 SHALL abandon any in-flight transaction on reset with no response issued; awready, wready and arready SHALL be 1 on the first cycle after reset release.

Structure
REQ-028 SHALL place register offsets (CMD/STATUS/SCRATCH/CMD_COUNT), the response codes OKAY/SLVERR and the FSM state encodings in the shared parameter definition header.
REQ-029 SHALL be a single module with no sub-modules; the write and read FSMs are separate always blocks.

Verification
REQ-030 Simultaneous AW+W write of 32'h1234ABCD to 0x0 with wstrb=F -> bvalid the next cycle with OKAY; cmd_data=32'h1234ABCD with a 1-cycle cmd_vld; CMD_COUNT reads 1.
REQ-031 W first, then AW 3 cycles later, writing 32'h11223344 to 0x0 -> a single commit only after AW; bvalid held 4 cycles while bready=0; exactly one cmd_vld pulse.
REQ-032 Write 32'hAABBCCDD to 0x8 with wstrb=4'b0101 after reset -> SCRATCH reads 32'h00BB00DD; a write to 0x4 returns SLVERR and STATUS is unchanged.
REQ-033 Preload CMD_COUNT at 32'hFFFF_FFFF via force, then one CMD write -> CMD_COUNT reads 0.
REQ-034 Read 0x4 with led0_in=1 and stop_in=0 while rready is held low 5 cycles -> rdata=32'h1 is stable throughout; arready=0 until the R handshake completes.
REQ-035 Assert usr_rst_n low while in W_HAVE_A -> no bvalid is issued; after release, a fresh write completes normally; cmd_data=0 until that write.

Source files
------------

// File: rtl/axil_cmd_slave_pkg.sv
// Shared definitions for the AXI-Lite command slave: register offsets,
// response codes, FSM encodings and the write-request payload.
package axil_cmd_slave_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned RESP_W    = 2;
  localparam int unsigned REG_SEL_W = 2;

  // Register selects, i.e. address bits [3:2]
  localparam logic [REG_SEL_W-1:0] REG_CMD       = 2'd0;  // 0x0
  localparam logic [REG_SEL_W-1:0] REG_STATUS    = 2'd1;  // 0x4
  localparam logic [REG_SEL_W-1:0] REG_SCRATCH   = 2'd2;  // 0x8
  localparam logic [REG_SEL_W-1:0] REG_CMD_COUNT = 2'd3;  // 0xC

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // Fully assembled write request at the point of commit
  typedef struct packed {
    logic [REG_SEL_W-1:0] sel;
    logic [DATA_W-1:0]    data;
    logic [STRB_W-1:0]    strb;
  } wr_req_t;

  // Byte-lane merge of new data into an existing register value
  function automatic logic [DATA_W-1:0] apply_strb(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_cmd_slave.sv
// AXI-Lite slave exposing a CMD word to the LED/stop decoder, a status
// readback, a scratch register and a count of committed CMD writes.
module axil_cmd_slave
  import axil_cmd_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic              usr_clk,
  input  logic              usr_rst_n,
  // write address
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  // write data
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  // write response
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  // read address
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  // read data
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  // downstream command decoder
  output logic [31:0]       cmd_data,
  output logic              cmd_vld,
  input  logic              led0_in,
  input  logic              stop_in
);

  wr_state_e w_state, w_state_nxt;
  rd_state_e r_state, r_state_nxt;

  logic [REG_SEL_W-1:0] aw_sel_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [STRB_W-1:0]    wstrb_q;

  logic [DATA_W-1:0]    scratch;
  logic [DATA_W-1:0]    cmd_count;

  logic                 aw_hs_c;
  logic                 w_hs_c;
  logic                 b_hs_c;
  logic                 ar_hs_c;
  logic                 r_hs_c;
  logic                 commit_c;
  logic                 cmd_inc_c;
  wr_req_t              req_c;
  logic [RESP_W-1:0]    wr_resp_c;
  logic [DATA_W-1:0]    rd_mux_c;

  // Only bits [3:2] of either address are decoded
  logic                 unused_addr_bits;
  assign unused_addr_bits = ^{s_axil_awaddr, s_axil_araddr};

  assign aw_hs_c = s_axil_awvalid & s_axil_awready;
  assign w_hs_c  = s_axil_wvalid  & s_axil_wready;
  assign b_hs_c  = s_axil_bvalid  & s_axil_bready;
  assign ar_hs_c = s_axil_arvalid & s_axil_arready;
  assign r_hs_c  = s_axil_rvalid  & s_axil_rready;

  // ---------------------------------------------------------------- write

  // Write FSM state register
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) w_state <= W_IDLE;
    else            w_state <= w_state_nxt;
  end

  // Write next-state; assembles the request from live or latched halves
  always_comb begin
    w_state_nxt = w_state;
    commit_c    = 1'b0;
    req_c       = '{sel: aw_sel_q, data: wdata_q, strb: wstrb_q};
    case (w_state)
      W_IDLE: begin
        if (aw_hs_c && w_hs_c) begin
          w_state_nxt = W_RESP;
          commit_c    = 1'b1;
          req_c       = '{sel: s_axil_awaddr[3:2], data: s_axil_wdata, strb: s_axil_wstrb};
        end else if (aw_hs_c) begin
          w_state_nxt = W_HAVE_A;
        end else if (w_hs_c) begin
          w_state_nxt = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs_c) begin
          w_state_nxt = W_RESP;
          commit_c    = 1'b1;
          req_c       = '{sel: aw_sel_q, data: s_axil_wdata, strb: s_axil_wstrb};
        end
      end
      W_HAVE_D: begin
        if (aw_hs_c) begin
          w_state_nxt = W_RESP;
          commit_c    = 1'b1;
          req_c       = '{sel: s_axil_awaddr[3:2], data: wdata_q, strb: wstrb_q};
        end
      end
      W_RESP: begin
        if (b_hs_c) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign wr_resp_c = (req_c.sel == REG_CMD || req_c.sel == REG_SCRATCH) ? RESP_OKAY : RESP_SLVERR;
  assign cmd_inc_c = commit_c && (req_c.sel == REG_CMD) && (|req_c.strb);

  // Hold whichever half of the write arrived first
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      aw_sel_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs_c) aw_sel_q <= s_axil_awaddr[3:2];
      if (w_hs_c) begin
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
    end
  end

  // Write channel handshake outputs, registered from the next state
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      s_axil_awready <= 1'b1;
      s_axil_wready  <= 1'b1;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= RESP_OKAY;
    end else begin
      s_axil_awready <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_D);
      s_axil_wready  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_A);
      if (commit_c) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= wr_resp_c;
      end else if (b_hs_c) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  // Writable registers; cmd_vld marks the cycle cmd_data changes
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      cmd_data <= '0;
      cmd_vld  <= 1'b0;
      scratch  <= SCRATCH_RST;
    end else begin
      cmd_vld <= 1'b0;
      if (cmd_inc_c) begin
        cmd_data <= apply_strb(cmd_data, req_c.data, req_c.strb);
        cmd_vld  <= 1'b1;
      end
      if (commit_c && req_c.sel == REG_SCRATCH) begin
        scratch <= apply_strb(scratch, req_c.data, req_c.strb);
      end
    end
  end

  // Count of committed CMD words, wrapping naturally at 32 bits
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n)     cmd_count <= '0;
    else if (cmd_inc_c) cmd_count <= cmd_count + 32'd1;
  end

  // ----------------------------------------------------------------- read

  // Read FSM state register
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) r_state <= R_IDLE;
    else            r_state <= r_state_nxt;
  end

  // Read next-state
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs_c)  r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Read mux; registers hold pre-write values in a same-cycle collision
  always_comb begin
    rd_mux_c = '0;
    case (s_axil_araddr[3:2])
      REG_CMD:       rd_mux_c = cmd_data;
      REG_STATUS:    rd_mux_c = {30'b0, stop_in, led0_in};
      REG_SCRATCH:   rd_mux_c = scratch;
      REG_CMD_COUNT: rd_mux_c = cmd_count;
      default:       rd_mux_c = '0;
    endcase
  end

  // Read channel outputs; data captured at the AR handshake
  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      s_axil_arready <= 1'b1;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= RESP_OKAY;
    end else begin
      s_axil_arready <= (r_state_nxt == R_IDLE);
      if (ar_hs_c) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_mux_c;
        s_axil_rresp  <= RESP_OKAY;
      end else if (r_hs_c) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axil_cmd_slave.sv
// Directed bench for axil_cmd_slave.
module tb_axil_cmd_slave;

  logic        usr_clk;
  logic        usr_rst_n;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] cmd_data;
  logic        cmd_vld;
  logic        led0_in;
  logic        stop_in;

  int total_cnt  = 0;
  int passed_cnt = 0;
  int failed_cnt = 0;
  int pulses     = 0;

  axil_cmd_slave #(.ADDR_W(12), .SCRATCH_RST(32'h0000_0000)) dut (
    .usr_clk        (usr_clk),
    .usr_rst_n      (usr_rst_n),
    .s_axil_awaddr  (awaddr),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .cmd_data       (cmd_data),
    .cmd_vld        (cmd_vld),
    .led0_in        (led0_in),
    .stop_in        (stop_in)
  );

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  // Count cmd_vld pulses as seen at each active edge
  always @(posedge usr_clk) begin
    if (usr_rst_n && cmd_vld) pulses++;
  end

  task automatic tick();
    @(posedge usr_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) passed_cnt++;
    else begin
      failed_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    chk("wr_bvalid_seen", 32'(bvalid), 32'd1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    chk("rd_rvalid_seen", 32'(rvalid), 32'd1);
    d = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          p0;

    usr_rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; led0_in = 1'b0; stop_in = 1'b0;

    // Reset state
    #2;
    chk("rst_cmd_data", cmd_data, 32'h0);
    chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    tick(); tick();
    usr_rst_n = 1'b1;
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready", 32'(wready), 32'd1);
    chk("rel_arready", 32'(arready), 32'd1);

    // Simultaneous AW+W to CMD
    awaddr = 12'h000; wdata = 32'h1234ABCD; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("sim_bvalid", 32'(bvalid), 32'd1);
    chk("sim_bresp", 32'(bresp), 32'd0);
    chk("sim_cmd_data", cmd_data, 32'h1234ABCD);
    chk("sim_cmd_vld", 32'(cmd_vld), 32'd1);
    tick();
    chk("sim_cmd_vld_off", 32'(cmd_vld), 32'd0);
    chk("sim_bvalid_hold", 32'(bvalid), 32'd1);
    chk("sim_awready_resp", 32'(awready), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("sim_bvalid_done", 32'(bvalid), 32'd0);
    chk("sim_awready_idle", 32'(awready), 32'd1);
    do_read(12'h00C, d, r);
    chk("sim_count", d, 32'd1);
    chk("sim_count_rresp", 32'(r), 32'd0);

    // W first, AW three cycles later, bready held low
    p0 = pulses;
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wfirst_wready", 32'(wready), 32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    chk("wfirst_bvalid", 32'(bvalid), 32'd0);
    tick(); tick();
    chk("wfirst_no_commit", cmd_data, 32'h1234ABCD);
    chk("wfirst_no_vld", 32'(cmd_vld), 32'd0);
    awaddr = 12'h000; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wfirst_cmd_data", cmd_data, 32'h11223344);
    chk("wfirst_cmd_vld", 32'(cmd_vld), 32'd1);
    chk("wfirst_bvalid_on", 32'(bvalid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wfirst_bvalid_held", 32'(bvalid), 32'd1);
      chk("wfirst_bresp_held", 32'(bresp), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wfirst_bvalid_done", 32'(bvalid), 32'd0);
    chk("wfirst_one_pulse", 32'(pulses - p0), 32'd1);
    do_read(12'h00C, d, r);
    chk("wfirst_count", d, 32'd2);

    // Byte strobes on SCRATCH, SLVERR on read-only registers
    do_write(12'h008, 32'hAABBCCDD, 4'b0101, r);
    chk("scr_bresp", 32'(r), 32'd0);
    do_read(12'h008, d, r);
    chk("scr_rdata", d, 32'h00BB00DD);
    do_write(12'h004, 32'hFFFFFFFF, 4'hF, r);
    chk("status_wr_slverr", 32'(r), 32'd2);
    do_read(12'h004, d, r);
    chk("status_unchanged", d, 32'h0);
    do_write(12'h00C, 32'h0, 4'hF, r);
    chk("count_wr_slverr", 32'(r), 32'd2);
    do_read(12'h00C, d, r);
    chk("count_unchanged", d, 32'd2);
    p0 = pulses;
    do_write(12'h000, 32'hDEADBEEF, 4'h0, r);
    chk("strb0_bresp", 32'(r), 32'd0);
    do_read(12'h000, d, r);
    chk("strb0_cmd_kept", d, 32'h11223344);
    chk("strb0_no_pulse", 32'(pulses - p0), 32'd0);
    do_read(12'h10B, d, r);
    chk("alias_scratch", d, 32'h00BB00DD);

    // Read and write of SCRATCH in the same cycle returns the old value
    awaddr = 12'h008; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    araddr = 12'h008; arvalid = 1'b1; rready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata_old", rdata, 32'h00BB00DD);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    rready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    do_read(12'h008, d, r);
    chk("coll_scratch_new", d, 32'hCAFEF00D);

    // CMD_COUNT wraps
    force dut.cmd_count = 32'hFFFF_FFFF;
    tick();
    release dut.cmd_count;
    do_read(12'h00C, d, r);
    chk("wrap_preload", d, 32'hFFFF_FFFF);
    do_write(12'h000, 32'h0000_0055, 4'hF, r);
    chk("wrap_bresp", 32'(r), 32'd0);
    do_read(12'h00C, d, r);
    chk("wrap_count", d, 32'h0);
    chk("wrap_cmd_data", cmd_data, 32'h0000_0055);

    // STATUS sampled at AR, held while rready low
    led0_in = 1'b1; stop_in = 1'b0;
    araddr = 12'h004; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    led0_in = 1'b0; stop_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("status_rvalid", 32'(rvalid), 32'd1);
      chk("status_rdata", rdata, 32'h1);
      chk("status_arready", 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("status_rvalid_done", 32'(rvalid), 32'd0);
    chk("status_arready_back", 32'(arready), 32'd1);
    do_read(12'h004, d, r);
    chk("status_stop", d, 32'h2);
    stop_in = 1'b0;

    // Reset while in W_HAVE_A
    awaddr = 12'h000; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("hava_awready", 32'(awready), 32'd0);
    chk("hava_wready", 32'(wready), 32'd1);
    #2;
    usr_rst_n = 1'b0;
    #1;
    chk("mrst_cmd_data", cmd_data, 32'h0);
    chk("mrst_bvalid", 32'(bvalid), 32'd0);
    tick(); tick();
    usr_rst_n = 1'b1;
    chk("mrel_awready", 32'(awready), 32'd1);
    chk("mrel_wready", 32'(wready), 32'd1);
    chk("mrel_arready", 32'(arready), 32'd1);
    tick(); tick();
    chk("mrel_no_bvalid", 32'(bvalid), 32'd0);
    chk("mrel_cmd_data", cmd_data, 32'h0);
    do_write(12'h000, 32'h77, 4'hF, r);
    chk("mrel_bresp", 32'(r), 32'd0);
    chk("mrel_cmd_new", cmd_data, 32'h77);
    do_read(12'h00C, d, r);
    chk("mrel_count", d, 32'd1);
    do_read(12'h008, d, r);
    chk("mrel_scratch_rst", d, 32'h0);

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
